// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM slave bus for the LED pattern sequencer: register select,
// write strobe and zero-wait-state read data.
interface led_pattern_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Plays a programmable on/off pattern on one LED, one step per period_in clocks,
// with finite repeat or continuous loop, sticky done flag and level irq.
module led_pattern_sequencer #(
  parameter int PERIOD_W  = 24,
  parameter int PATTERN_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PERIOD_W-1:0]     period_in,
  led_pattern_sequencer_if.slave  bus,
  output logic                    led_out,
  output logic                    irq
);
  localparam int LEN_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
  typedef struct packed {
    logic [PATTERN_W-1:0] pattern;
    logic [LEN_W-1:0]     len_m1;
  } cfg_t;

  state_t              state, state_nxt;
  cfg_t                cfg_r, sh_r, sh_nxt;
  logic [7:0]          repeat_r, passes, passes_nxt;
  logic                loop_r, irq_en_r, done_r, done_nxt;
  logic [LEN_W-1:0]    step, step_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt;
  logic                led_nxt, adv;
  logic                wr, start, stop, clr_done, busy;
  logic [31:0]         rd;
  logic                unused_bits;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign start    = wr && (bus.address == 2'd0) && bus.writedata[0];
  assign stop     = wr && (bus.address == 2'd0) && bus.writedata[1];
  assign clr_done = wr && (bus.address == 2'd3) && bus.writedata[1];
  assign busy     = (state != IDLE);
  assign irq      = done_r & irq_en_r;
  assign unused_bits = ^bus.writedata;

  // Programmer-visible registers; CFG/REPEAT only reach the sequencer via start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_r   <= 1'b0;
      irq_en_r <= 1'b0;
      cfg_r    <= '0;
      repeat_r <= '0;
    end else if (wr) begin
      case (bus.address)
        2'd0: begin
          loop_r   <= bus.writedata[2];
          irq_en_r <= bus.writedata[3];
        end
        2'd1: begin
          cfg_r.pattern <= bus.writedata[PATTERN_W-1:0];
          cfg_r.len_m1  <= bus.writedata[16 +: LEN_W];
        end
        2'd2: repeat_r <= bus.writedata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sh_r    <= '0;
      step    <= '0;
      passes  <= '0;
      cnt     <= '0;
      led_out <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sh_r    <= sh_nxt;
      step    <= step_nxt;
      passes  <= passes_nxt;
      cnt     <= cnt_nxt;
      led_out <= led_nxt;
      done_r  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh_r;
    step_nxt   = step;
    passes_nxt = passes;
    cnt_nxt    = cnt;
    led_nxt    = led_out;
    done_nxt   = done_r;
    adv        = 1'b0;
    if (clr_done) done_nxt = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      led_nxt   = 1'b0;
    end else if (start) begin
      sh_nxt     = cfg_r;
      step_nxt   = '0;
      passes_nxt = repeat_r;
      done_nxt   = 1'b0;
      if (period_in != '0) begin
        state_nxt = RUN;
        cnt_nxt   = period_in - 1'b1;
        led_nxt   = cfg_r.pattern[0];
      end else begin
        state_nxt = STALL;
        led_nxt   = 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            adv = 1'b1;
            if (step < sh_r.len_m1) begin
              step_nxt = step + 1'b1;
            end else if (passes != '0 || loop_r) begin
              step_nxt = '0;
              if (!loop_r) passes_nxt = passes - 1'b1;
            end else begin
              adv       = 1'b0;
              state_nxt = IDLE;
              led_nxt   = 1'b0;
              done_nxt  = 1'b1;
            end
            // Period is re-sampled only at a step boundary.
            if (adv) begin
              if (period_in == '0) begin
                state_nxt = STALL;
                led_nxt   = 1'b0;
              end else begin
                cnt_nxt = period_in - 1'b1;
                led_nxt = sh_r.pattern[step_nxt];
              end
            end
          end
        end
        STALL: begin
          if (period_in != '0) begin
            state_nxt = RUN;
            cnt_nxt   = period_in - 1'b1;
            led_nxt   = sh_r.pattern[step];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (bus.address)
      2'd0: begin
        rd[2] = loop_r;
        rd[3] = irq_en_r;
      end
      2'd1: begin
        rd[PATTERN_W-1:0] = cfg_r.pattern;
        rd[16 +: LEN_W]   = cfg_r.len_m1;
      end
      2'd2: rd[7:0] = repeat_r;
      default: begin
        rd[0]           = busy;
        rd[1]           = done_r;
        rd[8 +: LEN_W]  = step;
        rd[23:16]       = passes;
      end
    endcase
  end

  assign bus.readdata = rd;
endmodule
